// File: rtl/clfsr_pkg.sv
//------------------------------------------------------------------------------
// Module      : clfsr_pkg
// Description : Shared constants and parameter legality helper for clfsr_stream.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package clfsr_pkg;

  localparam logic [15:0] CLFSR_TAPS16    = 16'hB400;
  localparam logic [15:0] CLFSR_SEED_X16  = 16'h7EF0;
  localparam int          CLFSR_SEED_LFSR = 1;

  localparam int CLFSR_MIN_W      = 4;
  localparam int CLFSR_MIN_LFSR_W = 2;
  localparam int CLFSR_MIN_OUT_W  = 1;
  localparam int CLFSR_MAX_OUT_W  = 32;

  function automatic bit clfsr_params_legal(input int w, input int lfsr_w, input int out_w);
    return (w >= CLFSR_MIN_W) && (lfsr_w >= CLFSR_MIN_LFSR_W) &&
           (out_w >= CLFSR_MIN_OUT_W) && (out_w <= CLFSR_MAX_OUT_W);
  endfunction

endpackage

`default_nettype wire

// File: rtl/clfsr_map.sv
//------------------------------------------------------------------------------
// Module      : clfsr_map
// Description : Combinational logistic-type map x' = 1 - 2x^2 in signed Q1.(W-1).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module clfsr_map #(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] x_next
);

  localparam logic [W-1:0] c_one = {1'b0, {(W-1){1'b1}}};

  logic signed [2*W-1:0] w_sq;
  logic                  w_unused_sq;

  assign w_sq = $signed(x) * $signed(x);
  // (sq <<< 1)[2W-2:W-1] is sq[2W-3:W-2]; take it directly, all mod 2^W
  assign x_next = c_one - w_sq[2*W-3:W-2];
  assign w_unused_sq = ^{w_sq[2*W-1:2*W-2], w_sq[W-3:0]};

endmodule

`default_nettype wire

// File: rtl/clfsr_stream.sv
//------------------------------------------------------------------------------
// Module      : clfsr_stream
// Description : Chaotic-LFSR bit generator packed into OUT_W-bit valid/ready words.
//               Macro CLFSR_MIX_EN mixes the LFSR MSB in; undefined = map MSB only.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module clfsr_stream
  import clfsr_pkg::*;
#(
  parameter int                W         = 16,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS      = LFSR_W'(CLFSR_TAPS16),
  parameter int                OUT_W     = 8,
  parameter logic [LFSR_W-1:0] SEED_LFSR = LFSR_W'(CLFSR_SEED_LFSR),
  parameter logic [W-1:0]      SEED_X    = W'(CLFSR_SEED_X16)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              seed_valid,
  input  logic [LFSR_W-1:0] seed_lfsr,
  input  logic [W-1:0]      seed_x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data
);

  localparam int                 c_cnt_w = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(OUT_W - 1);

  if (!clfsr_params_legal(W, LFSR_W, OUT_W)) begin : g_param_check
    $error("clfsr_stream: illegal W/LFSR_W/OUT_W");
  end

  logic [W-1:0]       r_x;
  logic [W-1:0]       w_x_next;
  logic [OUT_W-1:0]   r_acc;
  logic [OUT_W-1:0]   r_out_data;
  logic [OUT_W-1:0]   w_word;
  logic [OUT_W:0]     w_shift;
  logic [c_cnt_w-1:0] r_count;
  logic               r_out_valid;
  logic               w_adv;
  logic               w_last;
  logic               w_bit;
  logic               w_lfsr_msb;
  logic               w_unused_shift;

  clfsr_map #(.W(W)) u_map (
    .x      (r_x),
    .x_next (w_x_next)
  );

  // A held word blocks stepping so no bit is lost or repeated under back-pressure
  assign w_adv          = en & ~seed_valid & ~(r_out_valid & ~out_ready);
  assign w_last         = (r_count == c_last);
  assign w_bit          = w_x_next[W-1] ^ w_lfsr_msb;
  assign w_shift        = {r_acc, w_bit};
  assign w_word         = w_shift[OUT_W-1:0];
  assign w_unused_shift = w_shift[OUT_W];

`ifdef CLFSR_MIX_EN
  localparam logic [LFSR_W-1:0] c_lfsr_rst = (SEED_LFSR == '0) ? LFSR_W'(1) : SEED_LFSR;

  if (!TAPS[LFSR_W-1]) begin : g_taps_check
    $error("clfsr_stream: TAPS must include bit LFSR_W-1");
  end

  logic [LFSR_W-1:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= c_lfsr_rst;
    end else if (seed_valid) begin
      r_lfsr <= (seed_lfsr == '0) ? LFSR_W'(1) : seed_lfsr;
    end else if (w_adv) begin
      r_lfsr <= {r_lfsr[LFSR_W-2:0], ^(r_lfsr & TAPS)};
    end
  end

  assign w_lfsr_msb = r_lfsr[LFSR_W-1];
`else
  logic w_unused_lfsr;

  assign w_unused_lfsr = ^{seed_lfsr, TAPS, SEED_LFSR};
  assign w_lfsr_msb    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x         <= SEED_X;
      r_acc       <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (seed_valid) begin
      r_x         <= seed_x;
      r_acc       <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else if (en) begin
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_adv) begin
        r_x   <= w_x_next;
        r_acc <= w_word;
        // A completing word overrides the handshake clear on the same edge
        if (w_last) begin
          r_count     <= '0;
          r_out_valid <= 1'b1;
          r_out_data  <= w_word;
        end else begin
          r_count <= r_count + c_cnt_w'(1);
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

`default_nettype wire

// File: tb/tb_clfsr_stream.sv
//------------------------------------------------------------------------------
// Module      : tb_clfsr_stream
// Description : Directed bench for clfsr_stream (OUT_W=4) with a word scoreboard.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_clfsr_stream;

  localparam int OUT_W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        seed_valid;
  logic [15:0] seed_lfsr;
  logic [15:0] seed_x;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic [15:0] kat_x;
  logic [15:0] kat_nx;

  int total = 0;
  int bad   = 0;
  int n_hs  = 0;

  logic [3:0]  exp_q[$];
  logic [15:0] m_lfsr;
  logic [15:0] m_x;

  always #5 clk = ~clk;

  clfsr_stream #(.OUT_W(OUT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .seed_valid (seed_valid),
    .seed_lfsr  (seed_lfsr),
    .seed_x     (seed_x),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  clfsr_map #(.W(16)) u_kat (
    .x      (kat_x),
    .x_next (kat_nx)
  );

  // x' = 0x7FFF - ((2*x*x) >> 15), wrapped to 16 bits
  function automatic logic [15:0] f_map(input logic [15:0] x);
    logic signed [31:0] sq;
    logic        [31:0] dbl;
    sq  = $signed(x) * $signed(x);
    dbl = sq << 1;
    return 16'h7FFF - dbl[30:15];
  endfunction

  task automatic push_words(input int n);
    logic [3:0]  w;
    logic [15:0] fx;
    logic        b;
    for (int i = 0; i < n; i++) begin
      w = '0;
      for (int j = 0; j < OUT_W; j++) begin
        fx = f_map(m_x);
        b  = fx[15];
`ifdef CLFSR_MIX_EN
        b  = b ^ m_lfsr[15];
`endif
        m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
        m_x    = fx;
        w      = {w[2:0], b};
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic reseed(input logic [15:0] l, input logic [15:0] x);
    m_lfsr = (l == 16'h0) ? 16'h1 : l;
    m_x    = x;
    exp_q.delete();
    push_words(48);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop one expected word per accepted handshake
  always @(negedge clk) begin
    logic [3:0] e;
    if (!rst && en && !seed_valid && out_valid && out_ready) begin
      n_hs++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $error("FAIL sb_empty: observed=%0h expected=<none>", out_data);
      end else begin
        e = exp_q.pop_front();
        assert (out_data === e) else begin
          bad++;
          $error("FAIL sb_word: observed=%0h expected=%0h", out_data, e);
        end
      end
    end
  end

  initial begin
    int         n0;
    logic [3:0] hold;
    logic [3:0] first_8000;

`ifdef CLFSR_MIX_EN
    first_8000 = 4'h6;
`else
    first_8000 = 4'hE;
`endif
    rst = 1'b1; en = 1'b0; seed_valid = 1'b0; out_ready = 1'b1;
    seed_lfsr = '0; seed_x = '0;

    // Map known-answer sequence
    kat_x = 16'h7EF0; #1 check("kat1", 32'(kat_nx), 32'h843B);
    kat_x = 16'h843B; #1 check("kat2", 32'(kat_nx), 32'h90A4);
    kat_x = 16'h90A4; #1 check("kat3", 32'(kat_nx), 32'hBE3C);
    kat_x = 16'hBE3C; #1 check("kat4", 32'(kat_nx), 32'h3C6B);
    kat_x = 16'h0000; #1 check("kat_zero", 32'(kat_nx), 32'h7FFF);

    tick(2);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data", 32'(out_data), 32'h0);

    // Default seeds: first word after the 4th advancing edge
    reseed(16'h0001, 16'h7EF0);
    rst = 1'b0; en = 1'b1;
    tick(3);
    check("lat_not_yet", 32'(out_valid), 32'h0);
    tick(1);
    check("lat_valid", 32'(out_valid), 32'h1);
    check("lat_data", 32'(out_data), 32'hE);
    n0 = n_hs;
    tick(16);
    check("throughput", 32'(n_hs - n0), 32'd4);

    // Stall: word holds, no advance, stream resumes seamlessly
    out_ready = 1'b0;
    tick(1);
    hold = out_data;
    n0 = n_hs;
    check("stall_valid0", 32'(out_valid), 32'h1);
    tick(9);
    check("stall_valid", 32'(out_valid), 32'h1);
    check("stall_data", 32'(out_data), 32'(hold));
    check("stall_no_hs", 32'(n_hs - n0), 32'd0);
    out_ready = 1'b1;
    tick(12);

    // Reseed LFSR=0x8000
    seed_valid = 1'b1; seed_lfsr = 16'h8000; seed_x = 16'h7EF0;
    reseed(16'h8000, 16'h7EF0);
    tick(1);
    seed_valid = 1'b0;
    check("seed_clr_valid", 32'(out_valid), 32'h0);
    tick(4);
    check("seed8000_valid", 32'(out_valid), 32'h1);
    check("seed8000_word", 32'(out_data), 32'(first_8000));
    tick(8);

    // Zero LFSR seed behaves as seed 1
    seed_valid = 1'b1; seed_lfsr = 16'h0000; seed_x = 16'h7EF0;
    reseed(16'h0000, 16'h7EF0);
    tick(1);
    seed_valid = 1'b0;
    tick(4);
    check("seed0_word", 32'(out_data), 32'hE);
    tick(8);

    // Reseed while a word is pending discards it
    out_ready = 1'b0;
    tick(4);
    check("pend_valid", 32'(out_valid), 32'h1);
    seed_valid = 1'b1; seed_lfsr = 16'h8000; seed_x = 16'h7EF0;
    reseed(16'h8000, 16'h7EF0);
    tick(1);
    seed_valid = 1'b0; out_ready = 1'b1;
    check("pend_discard", 32'(out_valid), 32'h0);
    tick(4);
    check("pend_restart", 32'(out_data), 32'(first_8000));

    // Reset mid-word
    tick(2);
    rst = 1'b1;
    reseed(16'h0001, 16'h7EF0);
    tick(1);
    check("midrst_valid", 32'(out_valid), 32'h0);
    check("midrst_data", 32'(out_data), 32'h0);
    rst = 1'b0;
    tick(4);
    check("midrst_word", 32'(out_data), 32'hE);

    // en=0 freezes everything, including a presented word
    en = 1'b0;
    hold = out_data;
    n0 = n_hs;
    tick(5);
    check("en0_valid", 32'(out_valid), 32'h1);
    check("en0_data", 32'(out_data), 32'(hold));
    check("en0_no_hs", 32'(n_hs - n0), 32'd0);
    en = 1'b1;
    tick(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clfsr_stream.md
# clfsr_stream

Parametrised chaotic-LFSR bit generator with word packing and a valid/ready output stream. Each step advances a Fibonacci LFSR and a fixed-point logistic-type map (x' = 1 − 2x²), XORs their MSBs into one bit, and packs OUT_W bits per output word. The block adds run-time reseeding, enable, and back-pressure, and sits between the entropy core and any word-wide consumer such as a FIFO or bus slave.

## Interface
- W, 16: map state width, signed Q1.(W-1); legal range ≥ 4
- LFSR_W, 16: LFSR width; legal range ≥ 2
- TAPS, 16'hB400: feedback mask, LFSR_W bits; bit LFSR_W-1 must be set
- OUT_W, 8: bits per output word, 1..32
- SEED_LFSR, 1: LFSR reset value; 0 is replaced by 1
- SEED_X, 16'h7EF0: map reset value (≈0.9917), W bits
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high, sampled on the rising edge of clk
- en  in  1  step enable
- seed_valid  in  1  load seed_lfsr/seed_x this cycle
- seed_lfsr  in  LFSR_W  LFSR seed
- seed_x  in  W  map seed
- out_valid  out  1  out_data holds a complete word
- out_ready  in  1  consumer accepts the word
- out_data  out  OUT_W  packed word; first generated bit in the MSB

## Operation
- Map step f(x): sq = x·x (2W signed); prod = sq <<< 1; x' = (2^(W-1) − 1) − prod[2W-2:W-1]. All arithmetic wraps modulo 2^W with no saturation.
- LFSR step: fb = XOR of lfsr bits selected by TAPS. Next lfsr = {lfsr[LFSR_W-2:0], fb}.
- advance = en & ~seed_valid & ~(out_valid & ~out_ready).
- On advance:
  - b = lfsr[LFSR_W-1] (pre-shift) ^ f(x)[W-1]
  - x <= f(x); lfsr shifts
  - b shifts into the accumulator LSB; bit counter increments
- Word complete: an advance with count == OUT_W-1 sets out_data <= {acc[OUT_W-2:0], b}, out_valid <= 1, count <= 0.
- Handshake: out_valid & out_ready at an edge clears out_valid, unless a new word completes on the same edge, in which case out_valid stays 1 with the new data.
- Seed load (seed_valid = 1):
  - lfsr <= seed_lfsr, or 1 if seed_lfsr is 0
  - x <= seed_x
  - count, acc, and out_valid are cleared; a pending word is discarded
  - no step occurs that edge; seed_valid has priority over en and the handshake
- en = 0: all state holds, including out_valid and out_data.
- out_data is stable while out_valid = 1 and out_ready = 0.

## Timing
- Reset values: out_valid 0, out_data 0, count 0, acc 0, lfsr SEED_LFSR (1 if 0), x SEED_X.
- rst has priority over everything; a reset mid-word discards the partial word.
- Latency: with en = 1 continuously, out_valid first rises after the OUT_W-th advancing edge.
- Throughput: one word per OUT_W cycles with out_ready = 1; one word per cycle when OUT_W = 1. No bubble at word boundaries.
- Map evaluation is single-cycle combinational: one W×W multiplier, register to register.
- Stall: while out_valid & ~out_ready, lfsr and x freeze. The sequence resumes with no lost or repeated bits.

## Configuration
- CLFSR_MIX_EN defined: b = LFSR MSB ^ map MSB, as specified above.
- CLFSR_MIX_EN undefined: b = map MSB only. LFSR logic is removed, and seed_lfsr, SEED_LFSR, and TAPS are ignored. Ports are unchanged.

## Structure
- Package clfsr_pkg holds:
  - CLFSR_TAPS16 = 16'hB400
  - CLFSR_SEED_X16 = 16'h7EF0
  - CLFSR_SEED_LFSR = 1
  - legality-check constants for the parameters
- Sub-module clfsr_map: purely combinational f(x), parametrised by W, so it can later be pipelined or replaced by another map.

## Test plan
- Map known-answer, W=16: seed_x = 0x7EF0 -> x sequence 0x843B, 0x90A4, 0xBE3C, 0x3C6B.
- Reset, OUT_W=4, default seeds, en = 1, out_ready = 1 -> first out_valid after the 4th edge with out_data = 0xE; one word every 4 cycles thereafter.
- seed_valid with seed_lfsr = 0x8000 and seed_x = 0x7EF0, OUT_W=4:
  - CLFSR_MIX_EN defined -> first word 0x6
  - CLFSR_MIX_EN undefined -> first word 0xE
- seed_lfsr = 0 -> LFSR loads 1; output matches the default-seed word stream.
- out_ready held 0 for 10 cycles mid-stream -> out_data stable, no advance. After release, the word sequence is identical to an unstalled run.
- seed_valid or rst asserted with count = 2 and out_valid = 1 -> out_valid = 0 next cycle. The first word after that restarts from the new seed.
